// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter: binary state register with a registered Gray
// image, up/down counting, synchronous load, optional saturation and status flags.
module gray_counter_n #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] TOP = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_unf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_nxt;
    logic             w_hit_top;
    logic             w_hit_bot;

    // Terminal events only exist on an enabled, non-load edge at the end code.
    always_comb begin
        w_bin_nxt = r_bin;
        w_hit_top = 1'b0;
        w_hit_bot = 1'b0;
        if (Load) begin
            w_bin_nxt = LoadValue;
        end else if (En) begin
            if (Dir) begin
                if (r_bin == TOP) begin
                    w_hit_top = 1'b1;
                    w_bin_nxt = SATURATE ? r_bin : '0;
                end else begin
                    w_bin_nxt = r_bin + ONE;
                end
            end else begin
                if (r_bin == '0) begin
                    w_hit_bot = 1'b1;
                    w_bin_nxt = SATURATE ? r_bin : TOP;
                end else begin
                    w_bin_nxt = r_bin - ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_bin_nxt ^ (w_bin_nxt >> 1);
            r_wrap <= w_hit_top | w_hit_bot;
            if (w_hit_top) r_ovf <= 1'b1;
            if (w_hit_bot) r_unf <= 1'b1;
        end
    end

    assign Output    = r_gray;
    assign BinOut    = r_bin;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: three instances (3-bit wrap, 4-bit saturate, 5-bit wrap)
// share stimulus and are checked against an integer reference model.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       rst, en, dir, ld;
    logic [4:0] lv;

    logic [2:0] go3, bo3;
    logic [3:0] go4, bo4;
    logic [4:0] go5, bo5;
    logic       ov3, un3, wr3, ov4, un4, wr4, ov5, un5, wr5;

    int n_chk = 0;
    int n_fail = 0;

    int W[3]   = '{3, 4, 5};
    bit SAT[3] = '{1'b0, 1'b1, 1'b0};
    int m_b[3], m_ov[3], m_un[3], m_wr[3];

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u3 (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadValue(lv[2:0]),
        .Output(go3), .BinOut(bo3), .Overflow(ov3), .Underflow(un3), .Wrap(wr3));
    gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) u4 (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadValue(lv[3:0]),
        .Output(go4), .BinOut(bo4), .Overflow(ov4), .Underflow(un4), .Wrap(wr4));
    gray_counter_n #(.WIDTH(5), .SATURATE(1'b0)) u5 (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadValue(lv),
        .Output(go5), .BinOut(bo5), .Overflow(ov5), .Underflow(un5), .Wrap(wr5));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gray_of(input int d);
        case (d)
            0: gray_of = 32'(go3);
            1: gray_of = 32'(go4);
            default: gray_of = 32'(go5);
        endcase
    endfunction

    function automatic logic [31:0] bin_of(input int d);
        case (d)
            0: bin_of = 32'(bo3);
            1: bin_of = 32'(bo4);
            default: bin_of = 32'(bo5);
        endcase
    endfunction

    function automatic logic [2:0] flags_of(input int d);
        case (d)
            0: flags_of = {ov3, un3, wr3};
            1: flags_of = {ov4, un4, wr4};
            default: flags_of = {ov5, un5, wr5};
        endcase
    endfunction

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    function automatic int g2b(input logic [31:0] g, input int w);
        int acc = 0;
        int res = 0;
        for (int i = w - 1; i >= 0; i--) begin
            acc = acc ^ int'(g[i]);
            res = res | (acc << i);
        end
        return res;
    endfunction

    task automatic model(input bit r, l, e, d, input int v);
        for (int k = 0; k < 3; k++) begin
            int top = (1 << W[k]) - 1;
            m_wr[k] = 0;
            if (r) begin
                m_b[k] = 0; m_ov[k] = 0; m_un[k] = 0;
            end else if (l) begin
                m_b[k] = v % (top + 1);
            end else if (e && d) begin
                if (m_b[k] == top) begin
                    m_ov[k] = 1; m_wr[k] = 1;
                    if (!SAT[k]) m_b[k] = 0;
                end else m_b[k] = m_b[k] + 1;
            end else if (e) begin
                if (m_b[k] == 0) begin
                    m_un[k] = 1; m_wr[k] = 1;
                    if (!SAT[k]) m_b[k] = top;
                end else m_b[k] = m_b[k] - 1;
            end
        end
    endtask

    task automatic step(input bit r, l, e, d, input logic [4:0] v);
        logic [4:0] pg = go5;
        rst = r; ld = l; en = e; dir = d; lv = v;
        @(posedge clk);
        #1;
        model(r, l, e, d, int'(v));
        for (int k = 0; k < 3; k++) begin
            logic [2:0] f = flags_of(k);
            chk($sformatf("bin%0d", k), bin_of(k), 32'(m_b[k]));
            chk($sformatf("gray%0d", k), gray_of(k), 32'(m_b[k] ^ (m_b[k] >> 1)));
            chk($sformatf("dec%0d", k), 32'(g2b(gray_of(k), W[k])), 32'(m_b[k]));
            chk($sformatf("ovf%0d", k), 32'(f[2]), 32'(m_ov[k]));
            chk($sformatf("unf%0d", k), 32'(f[1]), 32'(m_un[k]));
            chk($sformatf("wrap%0d", k), 32'(f[0]), 32'(m_wr[k]));
        end
        if (!r && !l && e)
            chk("ham5", 32'($countones(pg ^ go5)), 32'd1);
    endtask

    initial begin
        int up_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
        rst = 1'b0; ld = 1'b0; en = 1'b0; dir = 1'b0; lv = '0;
        @(negedge clk);

        // Up-count wrap on the 3-bit instance
        step(1, 0, 0, 0, 0);
        chk("rst_gray3", 32'(go3), 0);
        chk("rst_flags3", 32'({ov3, un3, wr3}), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 1, 0);
            chk("up_seq3", 32'(go3), 32'(up_seq[i]));
            chk("up_wrap3", 32'(wr3), (i == 7) ? 32'd1 : 32'd0);
        end
        step(0, 0, 0, 1, 0);
        chk("ovf_sticky3", 32'(ov3), 1);
        chk("wrap_drop3", 32'(wr3), 0);

        // Down-count from reset
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("dn_gray3", 32'(go3), 32'h4);
        chk("dn_bin3", 32'(bo3), 32'h7);
        chk("dn_flags3", 32'({ov3, un3, wr3}), 32'b011);

        // Load beats En; Reset beats Load
        step(0, 1, 1, 1, 5'd5);
        chk("ld_bin3", 32'(bo3), 5);
        chk("ld_gray3", 32'(go3), 7);
        chk("ld_unf3", 32'(un3), 1);
        step(1, 1, 1, 1, 5'd5);
        chk("rst_ld3", 32'({go3, bo3, ov3, un3, wr3}), 0);

        // Saturation on the 4-bit instance
        step(0, 1, 0, 0, 5'd14);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0);
            chk("sat_bin4", 32'(bo4), 15);
            chk("sat_gray4", 32'(go4), 32'h8);
            chk("sat_wrap4", 32'(wr4), (i > 0) ? 32'd1 : 32'd0);
        end
        chk("sat_ovf4", 32'(ov4), 1);

        // Reset mid-count, then resume
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        chk("mid_rst3", 32'({go3, ov3, un3, wr3}), 0);
        step(0, 0, 1, 1, 0);
        chk("resume3a", 32'(go3), 1);
        step(0, 0, 1, 1, 0);
        chk("resume3b", 32'(go3), 3);

        // Random traffic; long runs in one direction exercise both ends
        for (int i = 0; i < 400; i++) begin
            bit r = ($urandom_range(0, 99) < 2);
            bit l = ($urandom_range(0, 99) < 8);
            bit e = ($urandom_range(0, 3) != 0);
            bit d = (i % 64 < 40) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            step(r, l, e, d, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
